psum_bank: RTL and testbench

- Partial-sum storage that answers the accumulator's memory-side interface.
- Serves read requests as memory_data/memory_addr/memory_valid beats with 1-cycle latency, and absorbs result write-backs.
- Zero-fills itself after reset or on command.
- Streams final sums out through a valid/ready drain port for the output stage.

---
 rtl/psum_pkg.sv | 26 ++
 rtl/psum_sram.sv | 29 ++
 rtl/psum_bank.sv | 192 +++++++++++++++++++
 tb/tb_psum_bank.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/psum_pkg.sv
// Shared definitions for the partial-sum bank and the accumulator that talks to it:
// default geometry, FSM state encoding and lane extraction from a packed word.
package psum_pkg;

    localparam int DATA_W     = 512;
    localparam int ADDR_W     = 8;
    localparam int DEPTH      = 256;
    localparam int LANES      = 36;
    localparam int LANE_W     = 12;
    localparam int WORD_IDX_W = $clog2(DATA_W);

    typedef enum logic [1:0] {
        CLEAR,
        IDLE,
        DRAIN
    } psum_state_t;

    // Lanes are packed from bit 0 upward; bits above LANES*LANE_W are not lane data.
    function automatic logic [LANE_W-1:0] lane_extract(input logic [DATA_W-1:0] word,
                                                       input logic [5:0]        idx);
        logic [WORD_IDX_W-1:0] base;
        base = WORD_IDX_W'(idx) * WORD_IDX_W'(LANE_W);
        return word[base +: LANE_W];
    endfunction

endpackage

// File: rtl/psum_sram.sv
// Partial-sum storage array: one write port, one registered read port, no reset.
// Kept separate so a foundry macro can replace it without touching the control logic.
module psum_sram #(
    parameter int DATA_W = psum_pkg::DATA_W,
    parameter int ADDR_W = psum_pkg::ADDR_W,
    parameter int DEPTH  = psum_pkg::DEPTH
) (
    input  logic              clock,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Read-before-write on an address collision; the caller forwards when it needs new data.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/psum_bank.sv
// Partial-sum bank: zero-fill walk, 1-cycle reads with write forwarding, write-back, valid/ready drain.
// Define PSUM_BANK_CLR_ON_DRAIN_EN to zero each word as its drain beat is accepted.
module psum_bank #(
    parameter int DATA_W = psum_pkg::DATA_W,
    parameter int ADDR_W = psum_pkg::ADDR_W,
    parameter int DEPTH  = psum_pkg::DEPTH
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              rd_req_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic              rd_ready_o,
    output logic [DATA_W-1:0] memory_data_o,
    output logic [ADDR_W-1:0] memory_addr_o,
    output logic              memory_valid_o,
    input  logic [DATA_W-1:0] result_i,
    input  logic [ADDR_W-1:0] result_addr_i,
    input  logic              result_valid_i,
    input  logic              clear_start_i,
    input  logic              drain_start_i,
    output logic              busy_o,
    output logic [DATA_W-1:0] drain_data_o,
    output logic [ADDR_W-1:0] drain_addr_o,
    output logic              drain_valid_o,
    input  logic              drain_ready_i,
    output logic              err_o
);
    import psum_pkg::*;

    localparam int                IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int                AW1   = ADDR_W + 1;
    localparam logic [ADDR_W:0]   LIMIT = AW1'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

    psum_state_t       state;
    logic [ADDR_W-1:0] ptr;
    logic              drain_vld;

    logic              rd_acc;
    logic              rd_in_range;
    logic              wr_in_range;
    logic              wr_ok;
    logic              drain_acc;
    logic              drain_last;
    logic              fetch;

    logic              sram_we;
    logic [IDX_W-1:0]  sram_waddr;
    logic [DATA_W-1:0] sram_wdata;
    logic              sram_re;
    logic [IDX_W-1:0]  sram_raddr;
    logic [DATA_W-1:0] sram_rdata;

    logic              fwd_p1;
    logic              oor_p1;
    logic [DATA_W-1:0] fwd_data_p1;

    assign rd_ready_o  = (state == IDLE);
    assign busy_o      = (state != IDLE);
    assign rd_acc      = rd_req_i & rd_ready_o;
    assign rd_in_range = ({1'b0, rd_addr_i} < LIMIT);
    assign wr_in_range = ({1'b0, result_addr_i} < LIMIT);
    assign wr_ok       = result_valid_i & (state == IDLE) & wr_in_range;

    // Reset kills the drain beat in the reset cycle itself, not one edge later.
    assign drain_valid_o = drain_vld & ~reset;
    assign drain_acc     = drain_valid_o & drain_ready_i;
    assign drain_last    = drain_acc & (drain_addr_o == LAST);
    // Prefetch the next word whenever the output slot is empty or being emptied.
    assign fetch         = (state == DRAIN) & (~drain_vld | drain_acc) & ~drain_last;

    always_comb begin
        sram_we    = 1'b0;
        sram_waddr = IDX_W'(result_addr_i);
        sram_wdata = result_i;
        case (state)
            CLEAR: begin
                sram_we    = 1'b1;
                sram_waddr = IDX_W'(ptr);
                sram_wdata = '0;
            end
            IDLE: begin
                sram_we = wr_ok;
            end
`ifdef PSUM_BANK_CLR_ON_DRAIN_EN
            DRAIN: begin
                sram_we    = drain_acc;
                sram_waddr = IDX_W'(drain_addr_o);
                sram_wdata = '0;
            end
`endif
            default: begin
                sram_we = 1'b0;
            end
        endcase
    end

    assign sram_re    = fetch | (rd_acc & rd_in_range);
    assign sram_raddr = (state == DRAIN) ? IDX_W'(ptr) : IDX_W'(rd_addr_i);

    psum_sram #(
        .DATA_W (DATA_W),
        .ADDR_W (IDX_W),
        .DEPTH  (DEPTH)
    ) u_sram (
        .clock   (clock),
        .wr_en   (sram_we),
        .wr_addr (sram_waddr),
        .wr_data (sram_wdata),
        .rd_en   (sram_re),
        .rd_addr (sram_raddr),
        .rd_data (sram_rdata)
    );

    // ---- p0 -> p1: control state, read-return tags, drain slot ----
    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= CLEAR;
            ptr            <= '0;
            drain_vld      <= 1'b0;
            drain_addr_o   <= '0;
            memory_valid_o <= 1'b0;
            memory_addr_o  <= '0;
            fwd_p1         <= 1'b0;
            oor_p1         <= 1'b0;
            err_o          <= 1'b0;
        end else begin
            memory_valid_o <= rd_acc;
            if (rd_acc) begin
                memory_addr_o <= rd_addr_i;
                fwd_p1        <= wr_ok & (result_addr_i == rd_addr_i);
                oor_p1        <= ~rd_in_range;
            end
            if ((result_valid_i & ~wr_ok) | (rd_acc & ~rd_in_range)) begin
                err_o <= 1'b1;
            end
            case (state)
                CLEAR: begin
                    if (ptr == LAST) begin
                        state <= IDLE;
                    end else begin
                        ptr <= ptr + 1'b1;
                    end
                end
                IDLE: begin
                    if (clear_start_i) begin
                        state <= CLEAR;
                        ptr   <= '0;
                    end else if (drain_start_i) begin
                        state <= DRAIN;
                        ptr   <= '0;
                    end
                end
                DRAIN: begin
                    if (fetch) begin
                        drain_vld    <= 1'b1;
                        drain_addr_o <= ptr;
                        ptr          <= ptr + 1'b1;
                    end else if (drain_acc) begin
                        drain_vld <= 1'b0;
                    end
                    if (drain_last) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= CLEAR;
                    ptr   <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (rd_acc) begin
            fwd_data_p1 <= result_i;
        end
    end

    always_comb begin
        if (!memory_valid_o || oor_p1) begin
            memory_data_o = '0;
        end else if (fwd_p1) begin
            memory_data_o = fwd_data_p1;
        end else begin
            memory_data_o = sram_rdata;
        end
    end

    assign drain_data_o = drain_valid_o ? sram_rdata : '0;

endmodule

// File: tb/tb_psum_bank.sv
// Randomized self-checking bench for psum_bank against an array-based model of the bank's rules.
// Runs with DEPTH=200 / ADDR_W=9 so out-of-range addresses are reachable.
module tb_psum_bank;

    localparam int DATA_W = 512;
    localparam int ADDR_W = 9;
    localparam int DEPTH  = 200;

    logic              clock;
    logic              reset;
    logic              rd_req_i;
    logic [ADDR_W-1:0] rd_addr_i;
    logic              rd_ready_o;
    logic [DATA_W-1:0] memory_data_o;
    logic [ADDR_W-1:0] memory_addr_o;
    logic              memory_valid_o;
    logic [DATA_W-1:0] result_i;
    logic [ADDR_W-1:0] result_addr_i;
    logic              result_valid_i;
    logic              clear_start_i;
    logic              drain_start_i;
    logic              busy_o;
    logic [DATA_W-1:0] drain_data_o;
    logic [ADDR_W-1:0] drain_addr_o;
    logic              drain_valid_o;
    logic              drain_ready_i;
    logic              err_o;

    logic [DATA_W-1:0] ref_mem [DEPTH];
    bit                err_exp;
    int                n_checks;
    int                n_fail;

    psum_bank #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .rd_req_i       (rd_req_i),
        .rd_addr_i      (rd_addr_i),
        .rd_ready_o     (rd_ready_o),
        .memory_data_o  (memory_data_o),
        .memory_addr_o  (memory_addr_o),
        .memory_valid_o (memory_valid_o),
        .result_i       (result_i),
        .result_addr_i  (result_addr_i),
        .result_valid_i (result_valid_i),
        .clear_start_i  (clear_start_i),
        .drain_start_i  (drain_start_i),
        .busy_o         (busy_o),
        .drain_data_o   (drain_data_o),
        .drain_addr_o   (drain_addr_o),
        .drain_valid_o  (drain_valid_o),
        .drain_ready_i  (drain_ready_i),
        .err_o          (err_o)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got still running, expected finished");
        $fatal(1, "simulation time limit reached");
    end

    task automatic check_val(input string tag, input logic [DATA_W-1:0] got,
                             input logic [DATA_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    function automatic logic [DATA_W-1:0] rand_word();
        logic [DATA_W-1:0] w;
        w = '0;
        for (int i = 0; i < DATA_W / 32; i++) begin
            w[i*32 +: 32] = $urandom();
        end
        return w;
    endfunction

    task automatic wait_clear(output int cnt);
        cnt = 0;
        while (busy_o && cnt < 4 * DEPTH) begin
            cnt++;
            tick();
        end
    endtask

    task automatic do_reset();
        int cnt;
        reset          = 1'b1;
        rd_req_i       = 1'b0;
        result_valid_i = 1'b0;
        clear_start_i  = 1'b0;
        drain_start_i  = 1'b0;
        drain_ready_i  = 1'b0;
        tick();
        tick();
        check_val("rst_busy", DATA_W'(busy_o), DATA_W'(1'b1));
        check_val("rst_rd_ready", DATA_W'(rd_ready_o), '0);
        check_val("rst_mem_valid", DATA_W'(memory_valid_o), '0);
        check_val("rst_mem_addr", DATA_W'(memory_addr_o), '0);
        check_val("rst_mem_data", memory_data_o, '0);
        check_val("rst_drain_valid", DATA_W'(drain_valid_o), '0);
        check_val("rst_drain_addr", DATA_W'(drain_addr_o), '0);
        check_val("rst_drain_data", drain_data_o, '0);
        check_val("rst_err", DATA_W'(err_o), '0);
        reset   = 1'b0;
        err_exp = 1'b0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        wait_clear(cnt);
        check_val("clear_cycles", DATA_W'(cnt), DATA_W'(DEPTH));
        check_val("idle_rd_ready", DATA_W'(rd_ready_o), DATA_W'(1'b1));
    endtask

    // One IDLE cycle with an optional read and an optional write-back, then check the read return.
    task automatic rd_wr(input bit rq, input int ra, input bit wv, input int wa,
                         input logic [DATA_W-1:0] wd);
        logic [DATA_W-1:0] exp_d;
        exp_d = '0;
        if (rq && ra < DEPTH) exp_d = (wv && wa == ra) ? wd : ref_mem[ra];
        rd_req_i       = rq;
        rd_addr_i      = ADDR_W'(ra);
        result_valid_i = wv;
        result_addr_i  = ADDR_W'(wa);
        result_i       = wd;
        if (wv) begin
            if (wa < DEPTH) ref_mem[wa] = wd;
            else err_exp = 1'b1;
        end
        if (rq && ra >= DEPTH) err_exp = 1'b1;
        tick();
        rd_req_i       = 1'b0;
        result_valid_i = 1'b0;
        check_val("rd_valid", DATA_W'(memory_valid_o), DATA_W'(rq));
        if (rq) begin
            check_val("rd_addr", DATA_W'(memory_addr_o), DATA_W'(ra));
            check_val("rd_data", memory_data_o, exp_d);
        end
        check_val("err", DATA_W'(err_o), DATA_W'(err_exp));
    endtask

    task automatic run_drain(input bit toggle, input bit inject_wr, input bit spam_rd,
                             input int reset_at, output int cycles);
        int idx;
        idx    = 0;
        cycles = 0;
        drain_start_i = 1'b1;
        tick();
        drain_start_i = 1'b0;
        while (idx < DEPTH && cycles < 8 * DEPTH) begin
            drain_ready_i = toggle ? ((cycles % 4 == 0) || (cycles % 4 == 3)) : 1'b1;
            rd_req_i      = spam_rd;
            rd_addr_i     = ADDR_W'($urandom_range(0, (1 << ADDR_W) - 1));
            check_val("drain_busy", DATA_W'(busy_o), DATA_W'(1'b1));
            check_val("drain_err", DATA_W'(err_o), DATA_W'(err_exp));
            if (spam_rd) check_val("drain_rd_ignored", DATA_W'(memory_valid_o), '0);
            if (drain_valid_o) begin
                if (idx == reset_at) begin
                    reset = 1'b1;
                    #1;
                    check_val("drain_vld_in_reset", DATA_W'(drain_valid_o), '0);
                    drain_ready_i = 1'b0;
                    rd_req_i      = 1'b0;
                    return;
                end
                check_val("drain_addr", DATA_W'(drain_addr_o), DATA_W'(idx));
                check_val("drain_data", drain_data_o, ref_mem[idx]);
                if (drain_ready_i) begin
`ifdef PSUM_BANK_CLR_ON_DRAIN_EN
                    ref_mem[idx] = '0;
`endif
                    idx++;
                end
            end
            if (inject_wr && cycles == 5) begin
                result_valid_i = 1'b1;
                result_addr_i  = ADDR_W'(DEPTH - 1);
                result_i       = '1;
                err_exp        = 1'b1;
            end else begin
                result_valid_i = 1'b0;
            end
            tick();
            cycles++;
        end
        drain_ready_i  = 1'b0;
        rd_req_i       = 1'b0;
        result_valid_i = 1'b0;
        check_val("drain_beats", DATA_W'(idx), DATA_W'(DEPTH));
        check_val("drain_done_busy", DATA_W'(busy_o), '0);
        check_val("drain_done_vld", DATA_W'(drain_valid_o), '0);
    endtask

    initial begin
        logic [DATA_W-1:0] w;
        int cyc;
        int ra;
        int wa;
        n_checks      = 0;
        n_fail        = 0;
        err_exp       = 1'b0;
        reset         = 1'b1;
        rd_req_i      = 1'b0;
        rd_addr_i     = '0;
        result_i      = '0;
        result_addr_i = '0;
        result_valid_i = 1'b0;
        clear_start_i = 1'b0;
        drain_start_i = 1'b0;
        drain_ready_i = 1'b0;

        do_reset();

        // Basic read of a cleared word, write then read, same-cycle forwarding.
        rd_wr(1'b1, 'h10, 1'b0, 0, '0);
        w = rand_word();
        w[11:0] = 12'hABC;
        rd_wr(1'b0, 0, 1'b1, 5, w);
        rd_wr(1'b1, 5, 1'b0, 0, '0);
        check_val("lane0", DATA_W'(psum_pkg::lane_extract(memory_data_o, 6'd0)), DATA_W'(12'hABC));
        rd_wr(1'b1, 7, 1'b1, 7, rand_word());

        repeat (80) begin
            ra = int'($urandom_range(0, DEPTH - 1));
            wa = ($urandom_range(0, 3) == 0) ? ra : int'($urandom_range(0, DEPTH - 1));
            rd_wr(1'($urandom_range(0, 1)), ra, 1'($urandom_range(0, 1)), wa, rand_word());
        end

        // Fill with i+1, drain with stalls while reads are offered and must be ignored.
        for (int i = 0; i < DEPTH; i++) rd_wr(1'b0, 0, 1'b1, i, DATA_W'(i + 1));
        run_drain(1'b1, 1'b0, 1'b1, -1, cyc);
        for (int i = 0; i < DEPTH; i++) rd_wr(1'b1, i, 1'b0, 0, '0);

        // Full-rate drain with a write-back that must be dropped.
        run_drain(1'b0, 1'b1, 1'b0, -1, cyc);
        check_val("drain_cycles", DATA_W'(cyc), DATA_W'(DEPTH + 1));

        // Clear and drain requested together: clear wins.
        for (int i = 0; i < DEPTH; i++) rd_wr(1'b0, 0, 1'b1, i, rand_word());
        clear_start_i = 1'b1;
        drain_start_i = 1'b1;
        tick();
        clear_start_i = 1'b0;
        drain_start_i = 1'b0;
        wait_clear(cyc);
        check_val("cmd_clear_cycles", DATA_W'(cyc), DATA_W'(DEPTH));
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        repeat (10) rd_wr(1'b1, int'($urandom_range(0, DEPTH - 1)), 1'b0, 0, '0);
        check_val("err_sticky", DATA_W'(err_o), DATA_W'(1'b1));

        // Reset in the middle of a drain.
        for (int i = 0; i < DEPTH; i++) rd_wr(1'b0, 0, 1'b1, i, rand_word());
        run_drain(1'b0, 1'b0, 1'b0, 50, cyc);
        do_reset();
        for (int i = 0; i < DEPTH; i++) rd_wr(1'b1, i, 1'b0, 0, '0);

        // Out-of-range accesses.
        rd_wr(1'b0, 0, 1'b1, 'h105, rand_word());
        rd_wr(1'b1, 5, 1'b0, 0, '0);
        rd_wr(1'b1, 'h100, 1'b0, 0, '0);
        repeat (3) rd_wr(1'b0, 0, 1'b0, 0, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
